// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use bubbles, memory-busy freeze,
// redirect flushes and HALT drain, plus a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int REG_BITS = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                id_halt,
  input  logic                ex_memread,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                ex_redirect,
  input  logic                mem_busy,
  input  logic                wb_halt,
  output logic                pc_stall,
  output logic                ifid_stall,
  output logic                ifid_flush,
  output logic                idex_stall,
  output logic                idex_flush,
  output logic                exmem_stall,
  output logic                memwb_flush,
  output logic                halted,
  output logic [CNT_W-1:0]    stall_cnt
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0] state;
  logic [1:0] state_next;
  logic       load_use;
  logic       pc_stall_c, ifid_stall_c, ifid_flush_c, idex_stall_c;
  logic       idex_flush_c, exmem_stall_c, memwb_flush_c;

  assign load_use = (ex_memread && (ex_rd == id_rs) && id_uses_rs) ||
                    (ex_memread && (ex_rd == id_rt) && id_uses_rt);

  always_comb begin
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_stall_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_stall_c = 1'b0;
    memwb_flush_c = 1'b0;
    state_next    = state;
    case (state)
      ST_RUN: begin
        if (mem_busy) begin
          {pc_stall_c, ifid_stall_c, idex_stall_c, exmem_stall_c, memwb_flush_c} = 5'b11111;
        end else if (ex_redirect) begin
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
        end else if (load_use) begin
          pc_stall_c   = 1'b1;
          ifid_stall_c = 1'b1;
          idex_flush_c = 1'b1;
        end else if (id_halt) begin
          pc_stall_c   = 1'b1;
          ifid_flush_c = 1'b1;
          state_next   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem_busy) begin
          {pc_stall_c, ifid_stall_c, idex_stall_c, exmem_stall_c, memwb_flush_c} = 5'b11111;
        end else if (ex_redirect) begin
          // HALT was on the wrong path of an older taken branch: resume fetching.
          ifid_flush_c = 1'b1;
          idex_flush_c = 1'b1;
          state_next   = ST_RUN;
        end else begin
          pc_stall_c   = 1'b1;
          ifid_flush_c = 1'b1;
        end
        // The instruction in WB is retiring regardless of a memory stall behind it.
        if (wb_halt) state_next = ST_HALTED;
      end
      ST_HALTED: begin
        {pc_stall_c, ifid_stall_c, idex_stall_c, exmem_stall_c, memwb_flush_c} = 5'b11111;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Controls are forced inactive for as long as reset is held.
  assign pc_stall    = pc_stall_c    & rst;
  assign ifid_stall  = ifid_stall_c  & rst;
  assign ifid_flush  = ifid_flush_c  & rst;
  assign idex_stall  = idex_stall_c  & rst;
  assign idex_flush  = idex_flush_c  & rst;
  assign exmem_stall = exmem_stall_c & rst;
  assign memwb_flush = memwb_flush_c & rst;
  assign halted      = (state == ST_HALTED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      stall_cnt <= '0;
    end else begin
      state <= state_next;
      if (pc_stall && (state != ST_HALTED) && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// expected controls come from a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int REG_BITS = 3;
  localparam int CNT_W    = 5;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  localparam int M_RUN = 0, M_DRAIN = 1, M_STOP = 2;

  typedef struct packed {
    logic                rst;
    logic [REG_BITS-1:0] id_rs;
    logic [REG_BITS-1:0] id_rt;
    logic                uses_rs;
    logic                uses_rt;
    logic                id_halt;
    logic                ex_memread;
    logic [REG_BITS-1:0] ex_rd;
    logic                ex_redirect;
    logic                mem_busy;
    logic                wb_halt;
  } stim_t;

  typedef struct packed {
    logic [7:0] ctrl;   // pc_stall ifid_stall ifid_flush idex_stall idex_flush exmem_stall memwb_flush halted
    int         cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [REG_BITS-1:0] id_rs, id_rt, ex_rd;
  logic id_uses_rs, id_uses_rt, id_halt, ex_memread, ex_redirect, mem_busy, wb_halt;
  logic pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush, halted;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  int m_mode = M_RUN;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_BITS(REG_BITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_halt(id_halt), .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .mem_busy(mem_busy), .wb_halt(wb_halt),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .idex_flush(idex_flush), .exmem_stall(exmem_stall),
    .memwb_flush(memwb_flush), .halted(halted), .stall_cnt(stall_cnt)
  );

  function automatic logic hazard(stim_t s);
    return s.ex_memread && ((s.uses_rs && s.ex_rd == s.id_rs) || (s.uses_rt && s.ex_rd == s.id_rt));
  endfunction

  // Expected controls for this cycle, from the written priority rules.
  function automatic exp_t predict(int mode, int cnt, stim_t s);
    exp_t e;
    e.ctrl = 8'b0;
    e.cnt  = s.rst ? cnt : 0;
    if (!s.rst) return e;
    if (mode == M_STOP)               e.ctrl = 8'b1101_0111;
    else if (s.mem_busy)              e.ctrl = 8'b1101_0110;
    else if (s.ex_redirect)           e.ctrl = 8'b0010_1000;
    else if (mode == M_DRAIN)         e.ctrl = 8'b1010_0000;
    else if (hazard(s))               e.ctrl = 8'b1100_1000;
    else if (s.id_halt)               e.ctrl = 8'b1010_0000;
    return e;
  endfunction

  task automatic advance_model(stim_t s, exp_t e);
    if (!s.rst) begin
      m_mode = M_RUN;
      m_cnt  = 0;
      return;
    end
    if (e.ctrl[7] && m_mode != M_STOP && m_cnt < CNT_MAX) m_cnt++;
    case (m_mode)
      M_RUN:   if (!s.mem_busy && !s.ex_redirect && !hazard(s) && s.id_halt) m_mode = M_DRAIN;
      M_DRAIN: if (s.wb_halt) m_mode = M_STOP;
               else if (!s.mem_busy && s.ex_redirect) m_mode = M_RUN;
      default: ;
    endcase
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic apply(stim_t s);
    exp_t e;
    rst = s.rst; id_rs = s.id_rs; id_rt = s.id_rt; id_uses_rs = s.uses_rs; id_uses_rt = s.uses_rt;
    id_halt = s.id_halt; ex_memread = s.ex_memread; ex_rd = s.ex_rd; ex_redirect = s.ex_redirect;
    mem_busy = s.mem_busy; wb_halt = s.wb_halt;
    e = predict(m_mode, m_cnt, s);
    exp_q.push_back(e);
    @(posedge clk);
    advance_model(s, e);
    #1;
  endtask

  task automatic check(string name, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic do_reset();
    stim_t s = idle();
    s.rst = 1'b0;
    apply(s);
  endtask

  // Monitor: pops one expectation per presented cycle and compares at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush, halted} !== e.ctrl) begin
          failures++;
          $display("FAIL ctrl t=%0t got=%b expected=%b", $time,
                   {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush, halted}, e.ctrl);
        end
        checks++;
        if (int'(stall_cnt) != e.cnt) begin
          failures++;
          $display("FAIL stall_cnt t=%0t got=%0d expected=%0d", $time, stall_cnt, e.cnt);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    rst = 1'b0; id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rs = 0; id_uses_rt = 0;
    id_halt = 0; ex_memread = 0; ex_redirect = 0; mem_busy = 0; wb_halt = 0;
    @(posedge clk); #1;

    // Reset held with hazards present: everything quiet.
    s = '0; s.mem_busy = 1; s.ex_memread = 1; s.uses_rs = 1;
    apply(s); apply(s);
    check("reset_cnt", int'(stall_cnt), 0);
    check("reset_halted", int'(halted), 0);

    // Load-use: one bubble.
    s = idle(); s.ex_memread = 1; s.ex_rd = 3; s.id_rs = 3; s.uses_rs = 1;
    apply(s);
    check("lu_cnt", int'(stall_cnt), 1);
    apply(idle());

    // Load-use with redirect: redirect wins, counter unchanged.
    s = idle(); s.ex_memread = 1; s.ex_rd = 5; s.id_rt = 5; s.uses_rt = 1; s.ex_redirect = 1;
    apply(s);
    check("lu_redir_cnt", int'(stall_cnt), 1);

    // mem_busy for 3 cycles.
    do_reset();
    s = idle(); s.mem_busy = 1;
    repeat (3) apply(s);
    apply(idle());
    check("busy3_cnt", int'(stall_cnt), 3);

    // HALT then wb_halt 3 cycles later.
    do_reset();
    s = idle(); s.id_halt = 1; apply(s);
    apply(idle()); apply(idle());
    s = idle(); s.wb_halt = 1; apply(s);
    repeat (3) apply(idle());
    check("halt_cnt", int'(stall_cnt), 4);
    check("halt_sticky", int'(halted), 1);

    // HALT on wrong path.
    do_reset();
    s = idle(); s.id_halt = 1; apply(s);
    s = idle(); s.ex_redirect = 1; apply(s);
    apply(idle());
    check("halt_redir_halted", int'(halted), 0);
    check("halt_redir_pc", int'(pc_stall), 0);

    // Reset asserted in DRAIN while memory is busy.
    do_reset();
    s = idle(); s.id_halt = 1; apply(s);
    s = idle(); s.mem_busy = 1; apply(s);
    s.rst = 1'b0; apply(s);
    apply(idle());
    check("drain_rst_cnt", int'(stall_cnt), 0);

    // mem_busy together with wb_halt in DRAIN.
    do_reset();
    s = idle(); s.id_halt = 1; apply(s);
    s = idle(); s.mem_busy = 1; s.wb_halt = 1; apply(s);
    apply(idle());
    check("busy_wbhalt_halted", int'(halted), 1);

    // Counter saturation.
    do_reset();
    s = idle(); s.mem_busy = 1;
    repeat (CNT_MAX + 8) apply(s);
    check("sat_cnt", int'(stall_cnt), CNT_MAX);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      s.rst         = ($urandom_range(0, 99) >= 3);
      s.id_rs       = REG_BITS'($urandom);
      s.id_rt       = REG_BITS'($urandom);
      s.uses_rs     = $urandom_range(0, 1);
      s.uses_rt     = $urandom_range(0, 1);
      s.ex_rd       = REG_BITS'($urandom);
      s.ex_memread  = ($urandom_range(0, 9) < 4);
      s.id_halt     = ($urandom_range(0, 9) == 0);
      s.ex_redirect = ($urandom_range(0, 99) < 15);
      s.mem_busy    = ($urandom_range(0, 99) < 25);
      s.wb_halt     = ($urandom_range(0, 99) < 15);
      apply(s);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_queue got=%0d expected=0", exp_q.size());
    end
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
